// File: rtl/npc_bp_unit.sv
// Next-PC selection for the IF stage with a direct-mapped BTB of 2-bit
// saturating counters, trained from EX-stage branch resolution.
module npc_bp_unit #(
    parameter int ADDR_W  = 32,
    parameter int ENTRIES = 64,
    parameter int CNT_W   = 32,
    parameter int PRED_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] PCF,
    input  logic [ADDR_W-1:0] PCE,
    input  logic              BrValidE,
    input  logic              BranchE,
    input  logic              PredTakenE,
    input  logic [ADDR_W-1:0] BranchTarget,
    input  logic              JalrE,
    input  logic [ADDR_W-1:0] JalrTarget,
    input  logic              JalD,
    input  logic [ADDR_W-1:0] JalTarget,
    output logic [ADDR_W-1:0] PC_In,
    output logic              PredTakenF,
    output logic              MispredE,
    output logic [CNT_W-1:0]  BrCount,
    output logic [CNT_W-1:0]  MissCount
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    logic              valid_q  [ENTRIES];
    logic              valid_d  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [TAG_W-1:0]  tag_d    [ENTRIES];
    logic [ADDR_W-1:0] target_q [ENTRIES];
    logic [ADDR_W-1:0] target_d [ENTRIES];
    logic [1:0]        ctr_q    [ENTRIES];
    logic [1:0]        ctr_d    [ENTRIES];
    logic [CNT_W-1:0]  br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;

    logic [IDX_W-1:0]  f_idx, e_idx;
    logic [TAG_W-1:0]  f_tag, e_tag;
    logic              f_hit, e_hit;

    assign f_idx = PCF[IDX_W+1:2];
    assign f_tag = PCF[ADDR_W-1:IDX_W+2];
    assign e_idx = PCE[IDX_W+1:2];
    assign e_tag = PCE[ADDR_W-1:IDX_W+2];
    assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign e_hit = valid_q[e_idx] && (tag_q[e_idx] == e_tag);

    assign PredTakenF = (PRED_EN != 0) && f_hit && ctr_q[f_idx][1];
    assign MispredE   = BrValidE && (BranchE != PredTakenE);

    always_comb begin
        PC_In = PCF + ADDR_W'(4);
        if (MispredE)
            PC_In = BranchE ? BranchTarget : PCE + ADDR_W'(4);
        else if (JalrE)
            PC_In = {JalrTarget[ADDR_W-1:1], 1'b0};
        else if (JalD)
            PC_In = JalTarget;
        else if (PredTakenF)
            PC_In = target_q[f_idx];
    end

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (BrValidE && (PRED_EN != 0)) begin
            if (e_hit) begin
                if (BranchE) begin
                    if (ctr_q[e_idx] != 2'b11) ctr_d[e_idx] = ctr_q[e_idx] + 2'b01;
                    target_d[e_idx] = BranchTarget;
                end else if (ctr_q[e_idx] != 2'b00) begin
                    ctr_d[e_idx] = ctr_q[e_idx] - 2'b01;
                end
            end else if (BranchE) begin
                // Allocation evicts whatever alias currently owns the slot.
                valid_d[e_idx]  = 1'b1;
                tag_d[e_idx]    = e_tag;
                target_d[e_idx] = BranchTarget;
                ctr_d[e_idx]    = 2'b10;
            end
        end
    end

    always_comb begin
        br_cnt_d   = br_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (BrValidE && (br_cnt_q != '1))  br_cnt_d   = br_cnt_q + CNT_W'(1);
        if (MispredE && (miss_cnt_q != '1)) miss_cnt_d = miss_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
            br_cnt_q   <= '0;
            miss_cnt_q <= '0;
        end else begin
            valid_q    <= valid_d;
            tag_q      <= tag_d;
            target_q   <= target_d;
            ctr_q      <= ctr_d;
            br_cnt_q   <= br_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign BrCount   = br_cnt_q;
    assign MissCount = miss_cnt_q;

endmodule

// File: tb/tb_npc_bp_unit.sv
// Directed checks of the predicting next-PC unit plus a randomised run of a
// static (PRED_EN=0) instance against a reference next-PC mux.
module tb_npc_bp_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PCF, PCE, BranchTarget, JalrTarget, JalTarget;
    logic        BrValidE, BranchE, PredTakenE, JalrE, JalD;

    logic [31:0] pc_in_p, br_p, miss_p;
    logic        pred_p, misp_p;
    logic [31:0] pc_in_s;
    logic        pred_s, misp_s;
    logic [1:0]  br_s, miss_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    npc_bp_unit #(.ADDR_W(32), .ENTRIES(64), .CNT_W(32), .PRED_EN(1)) dut_pred (
        .clk(clk), .rst(rst), .PCF(PCF), .PCE(PCE), .BrValidE(BrValidE),
        .BranchE(BranchE), .PredTakenE(PredTakenE), .BranchTarget(BranchTarget),
        .JalrE(JalrE), .JalrTarget(JalrTarget), .JalD(JalD), .JalTarget(JalTarget),
        .PC_In(pc_in_p), .PredTakenF(pred_p), .MispredE(misp_p),
        .BrCount(br_p), .MissCount(miss_p)
    );

    npc_bp_unit #(.ADDR_W(32), .ENTRIES(4), .CNT_W(2), .PRED_EN(0)) dut_static (
        .clk(clk), .rst(rst), .PCF(PCF), .PCE(PCE), .BrValidE(BrValidE),
        .BranchE(BranchE), .PredTakenE(PredTakenE), .BranchTarget(BranchTarget),
        .JalrE(JalrE), .JalrTarget(JalrTarget), .JalD(JalD), .JalTarget(JalTarget),
        .PC_In(pc_in_s), .PredTakenF(pred_s), .MispredE(misp_s),
        .BrCount(br_s), .MissCount(miss_s)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        BrValidE = 0; BranchE = 0; PredTakenE = 0; JalrE = 0; JalD = 0;
    endtask

    task automatic branch(input logic [31:0] pce, input logic taken,
                          input logic pred, input logic [31:0] tgt);
        BrValidE = 1; PCE = pce; BranchE = taken; PredTakenE = pred; BranchTarget = tgt;
    endtask

    logic [31:0] exp_pc;
    logic [1:0]  br_m, miss_m;

    initial begin
        rst = 1; PCF = 0; PCE = 0; BranchTarget = 0; JalrTarget = 0; JalTarget = 0;
        idle();
        tick();
        tick();
        rst = 0;

        // Reset state
        PCF = 32'h100; settle();
        check("rst_pc_in", pc_in_p, 32'h104);
        check("rst_pred", {31'b0, pred_p}, 0);
        check("rst_brcnt", br_p, 0);
        check("rst_misscnt", miss_p, 0);

        // First taken branch at 0x200 mispredicts and allocates
        branch(32'h200, 1, 0, 32'h180); settle();
        check("alloc_pc_in", pc_in_p, 32'h180);
        check("alloc_misp", {31'b0, misp_p}, 1);
        tick(); idle(); PCF = 32'h200; settle();
        check("alloc_pred", {31'b0, pred_p}, 1);
        check("alloc_target", pc_in_p, 32'h180);
        check("alloc_brcnt", br_p, 1);
        check("alloc_misscnt", miss_p, 1);

        // Three correctly predicted taken updates saturate the counter at 3
        for (int i = 0; i < 3; i++) begin
            branch(32'h200, 1, 1, 32'h180); settle();
            check("train_no_misp", {31'b0, misp_p}, 0);
            tick();
        end
        idle(); settle();
        check("sat_brcnt", br_p, 4);
        check("sat_misscnt", miss_p, 1);

        // Not-taken after predicted taken: redirect to PCE+4, ctr 3->2
        branch(32'h200, 0, 1, 32'h180); settle();
        check("nt_pc_in", pc_in_p, 32'h204);
        check("nt_misp", {31'b0, misp_p}, 1);
        tick(); idle(); settle();
        check("nt1_pred", {31'b0, pred_p}, 1);
        check("nt1_misscnt", miss_p, 2);

        // Second not-taken: lookup in the update cycle still sees ctr=2
        branch(32'h200, 0, 1, 32'h180); settle();
        check("same_cycle_pred", {31'b0, pred_p}, 1);
        tick(); idle(); settle();
        check("nt2_pred", {31'b0, pred_p}, 0);
        check("nt2_pc_in", pc_in_p, 32'h204);
        check("nt2_brcnt", br_p, 6);
        check("nt2_misscnt", miss_p, 3);

        // Retrain taken with a new target (ctr 1->2, target updated on hit)
        branch(32'h200, 1, 0, 32'h1C0); tick(); idle(); settle();
        check("retrain_pred", {31'b0, pred_p}, 1);
        check("retrain_target", pc_in_p, 32'h1C0);

        // Alias 0x200 + 4*64 shares the index but misses on tag
        PCF = 32'h300; settle();
        check("alias_pred", {31'b0, pred_p}, 0);
        check("alias_pc_in", pc_in_p, 32'h304);

        // Allocating the alias evicts the 0x200 entry
        branch(32'h300, 1, 0, 32'h500); tick(); idle(); settle();
        check("alias_alloc_target", pc_in_p, 32'h500);
        PCF = 32'h200; settle();
        check("evicted_pred", {31'b0, pred_p}, 0);

        // Priority: mispredict over jal, jalr over jal, jal over PC+4
        PCF = 32'h100; JalD = 1; JalTarget = 32'h400;
        branch(32'h600, 1, 0, 32'h700); settle();
        check("prio_misp_over_jal", pc_in_p, 32'h700);
        BrValidE = 0; settle();
        check("prio_jal", pc_in_p, 32'h400);
        JalrE = 1; JalrTarget = 32'h451; settle();
        check("prio_jalr_bit0", pc_in_p, 32'h450);
        idle();

        // PC+4 wraps
        PCF = 32'hFFFF_FFFC; settle();
        check("wrap_pc_in", pc_in_p, 32'h0);

        // Reset discards an in-flight allocation and clears the table
        rst = 1; branch(32'h800, 1, 0, 32'h900); tick(); rst = 0; idle();
        PCF = 32'h800; settle();
        check("rst_drop_pred", {31'b0, pred_p}, 0);
        check("rst_drop_pc_in", pc_in_p, 32'h804);
        PCF = 32'h300; settle();
        check("rst_clear_pred", {31'b0, pred_p}, 0);
        check("rst_clear_brcnt", br_p, 0);

        // Static instance: random stimulus vs reference mux, 2-bit saturating counters
        br_m = 0; miss_m = 0;
        for (int i = 0; i < 200; i++) begin
            PCF = $urandom & 32'hFFFF_FFFC; PCE = $urandom & 32'hFFFF_FFFC;
            BranchTarget = $urandom; JalrTarget = $urandom; JalTarget = $urandom;
            BrValidE = 1'($urandom_range(0, 1)); BranchE = 1'($urandom_range(0, 1));
            JalrE = 1'($urandom_range(0, 3) == 0); JalD = 1'($urandom_range(0, 3) == 0);
            PredTakenE = 0;
            settle();
            if (BrValidE && BranchE)  exp_pc = BranchTarget;
            else if (JalrE)           exp_pc = {JalrTarget[31:1], 1'b0};
            else if (JalD)            exp_pc = JalTarget;
            else                      exp_pc = PCF + 32'd4;
            check("static_pred", {31'b0, pred_s}, 0);
            check("static_pc_in", pc_in_s, exp_pc);
            if (BrValidE && br_m != 2'b11)             br_m++;
            if (BrValidE && BranchE && miss_m != 2'b11) miss_m++;
            tick();
            idle(); settle();
            check("static_brcnt", {30'b0, br_s}, {30'b0, br_m});
            check("static_misscnt", {30'b0, miss_s}, {30'b0, miss_m});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
